draw_char_overlay: RTL and testbench

- Text-overlay renderer for the VGA pixel stream.
- Computes character-cell coordinates and the glyph row for the current pixel, and drives them to an external char-map and font ROM chain.
- Consumes the returned 8-bit glyph row and paints foreground pixels onto the `vga_if` stream.
- Sits in the VGA pipeline after the background and rectangle stages, immediately before the output sync register.

---
 rtl/draw_char_overlay_if.sv | 14 +
 rtl/draw_char_overlay.sv | 134 +++++++++++++
 tb/tb_draw_char_overlay.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_char_overlay_if.sv
// VGA stream interface: timing counters, sync, blanking and 12-bit rgb.
// The "in" modport is used by stages consuming the stream, "out" by stages producing it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_char_overlay.sv
// Text overlay stage for the VGA pipeline.
// Addresses an external char-map/font ROM chain (one clock of latency) and paints
// set glyph pixels with FG_RGB. Every vga_out field is vga_in delayed by 3 clocks.
// Optional macro DRAW_CHAR_OVERLAY_BG_FILL_EN: cleared glyph pixels inside the box
// are painted BG_RGB (opaque box) instead of passing the input rgb through.
module draw_char_overlay #(
  parameter int unsigned XPOS   = 280,
  parameter int unsigned YPOS   = 104,
  parameter int unsigned COLS   = 16,
  parameter int unsigned ROWS   = 2,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.in          vga_in,
  input  logic [7:0] char_pixels,
  output logic [7:0] char_xy,
  output logic [3:0] char_line,
  vga_if.out         vga_out
);

  localparam logic [10:0] X_LO = 11'(XPOS);
  localparam logic [10:0] X_HI = 11'(XPOS + COLS * 8);
  localparam logic [10:0] Y_LO = 11'(YPOS);
  localparam logic [10:0] Y_HI = 11'(YPOS + ROWS * 16);

`ifdef DRAW_CHAR_OVERLAY_BG_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_sample_t;

  vga_sample_t in_sample;
  vga_sample_t s1;
  vga_sample_t s2;
  logic        in_box;
  logic [6:0]  x_rel;
  logic [7:0]  y_rel;
  logic        in_box_s1;
  logic        in_box_s2;
  logic [2:0]  bit_s1;
  logic [2:0]  bit_s2;
  logic        pix;
  logic        paint;
  logic [11:0] rgb_next;

  assign in_sample = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                       hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                       hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                       rgb:    vga_in.rgb};

  // Box membership and the low bits of the box-relative position; upper bits are never needed.
  always_comb begin
    in_box = (vga_in.hcount >= X_LO) && (vga_in.hcount < X_HI) &&
             (vga_in.vcount >= Y_LO) && (vga_in.vcount < Y_HI);
    x_rel  = 7'(vga_in.hcount - X_LO);
    y_rel  = 8'(vga_in.vcount - Y_LO);
  end

  // Stage 1: drive the ROM address and capture the pixel context it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_xy   <= 8'h00;
      char_line <= 4'h0;
      in_box_s1 <= 1'b0;
      bit_s1    <= 3'd0;
      s1        <= '0;
    end else begin
      char_xy   <= in_box ? {y_rel[7:4], x_rel[6:3]} : 8'h00;
      char_line <= in_box ? y_rel[3:0] : 4'h0;
      in_box_s1 <= in_box;
      bit_s1    <= x_rel[2:0];
      s1        <= in_sample;
    end
  end

  // Stage 2: wait one clock so the context lines up with the returning glyph row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_box_s2 <= 1'b0;
      bit_s2    <= 3'd0;
      s2        <= '0;
    end else begin
      in_box_s2 <= in_box_s1;
      bit_s2    <= bit_s1;
      s2        <= s1;
    end
  end

  // Pick the glyph bit (MSB is leftmost) and decide the pixel colour; blanking never gets painted.
  always_comb begin
    pix      = char_pixels[3'd7 - bit_s2];
    paint    = in_box_s2 && !s2.hblnk && !s2.vblnk;
    rgb_next = s2.rgb;
    if (paint && pix) begin
      rgb_next = FG_RGB;
    end else if (paint && FILL_EN) begin
      rgb_next = BG_RGB;
    end
  end

  // Stage 3: output register; timing fields pass through untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'h000;
    end else begin
      vga_out.hcount <= s2.hcount;
      vga_out.vcount <= s2.vcount;
      vga_out.hsync  <= s2.hsync;
      vga_out.vsync  <= s2.vsync;
      vga_out.hblnk  <= s2.hblnk;
      vga_out.vblnk  <= s2.vblnk;
      vga_out.rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_char_overlay.sv
// Testbench for draw_char_overlay: a registered ROM stand-in, a reference model
// of the overlay written from the box/cell arithmetic, a per-cycle compare and
// a few literal expectations on selected pixels.
module tb_draw_char_overlay;

  localparam int          XPOS   = 280;
  localparam int          YPOS   = 104;
  localparam int          COLS   = 16;
  localparam int          ROWS   = 2;
  localparam logic [11:0] FG_RGB = 12'hFFF;
  localparam logic [11:0] BG_RGB = 12'h000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_pixels;
  logic [7:0] char_xy;
  logic [3:0] char_line;

  vga_if vin ();
  vga_if vout ();

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  logic [11:0] cap [0:2047];
  logic [10:0] cap_v = 11'h7FF;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [7:0]  xy;
    logic [3:0]  line;
  } exp_t;

  exp_t pipe [3];

  draw_char_overlay #(
    .XPOS(XPOS), .YPOS(YPOS), .COLS(COLS), .ROWS(ROWS),
    .FG_RGB(FG_RGB), .BG_RGB(BG_RGB)
  ) dut (
    .clk(clk), .rst(rst), .vga_in(vin), .char_pixels(char_pixels),
    .char_xy(char_xy), .char_line(char_line), .vga_out(vout)
  );

  // Pixel clock.
  always #5 clk = ~clk;

  // Glyph content selected by the current bench mode.
  function automatic logic [7:0] glyph(int m, logic [7:0] xy, logic [3:0] ln);
    case (m)
      0:       return 8'b1000_0001;
      1:       return 8'hFF;
      2:       return 8'h0F;
      default: return xy ^ {ln, ln} ^ 8'h5A;
    endcase
  endfunction

  // Char map plus font ROM: glyph row appears one clock after the address.
  always @(posedge clk) char_pixels <= glyph(mode, char_xy, char_line);

  // What the block must produce for one input pixel, from box and cell arithmetic.
  function automatic exp_t model(logic [10:0] h, logic [10:0] v, logic hs, logic vs,
                                 logic hb, logic vb, logic [11:0] rgb, int m);
    exp_t e;
    int xr, yr;
    bit inb;
    logic [7:0] g;
    e = '{h: h, v: v, hs: hs, vs: vs, hb: hb, vb: vb, rgb: rgb, xy: 8'h00, line: 4'h0};
    inb = (h >= XPOS) && (h < XPOS + COLS * 8) && (v >= YPOS) && (v < YPOS + ROWS * 16);
    if (inb) begin
      xr     = int'(h) - XPOS;
      yr     = int'(v) - YPOS;
      e.xy   = 8'((yr / 16) * 16 + xr / 8);
      e.line = 4'(yr % 16);
      g      = glyph(m, e.xy, e.line);
      if (!hb && !vb) begin
        if (g[7 - (xr % 8)]) e.rgb = FG_RGB;
`ifdef DRAW_CHAR_OVERLAY_BG_FILL_EN
        else e.rgb = BG_RGB;
`endif
      end
    end
    return e;
  endfunction

  // Model pipeline: an input sampled at an edge reaches the output two edges later; reset clears it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= model(vin.hcount, vin.vcount, vin.hsync, vin.vsync,
                       vin.hblnk, vin.vblnk, vin.rgb, mode);
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    exp_t act, exp;
    act = '{h: vout.hcount, v: vout.vcount, hs: vout.hsync, vs: vout.vsync,
            hb: vout.hblnk, vb: vout.vblnk, rgb: vout.rgb, xy: char_xy, line: char_line};
    exp = pipe[2];
    exp.xy   = pipe[0].xy;
    exp.line = pipe[0].line;
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL cycle_compare t=%0t got=%h expected=%h", $time, act, exp);
    end
    if (rst && vout.vcount == cap_v) cap[vout.hcount] = vout.rgb;
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(int h, int v, bit hb, bit vb, logic [11:0] rgb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = vin.hcount[4];
    vin.vsync  = vin.vcount[1];
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b1, 1'b1, 12'hABC);
  endtask

  task automatic randomPixel();
    applyStimulus($urandom_range(0, 2047), $urandom_range(0, 2047),
                  1'($urandom), 1'($urandom), 12'($urandom));
  endtask

  initial begin
    mode = 3;
    rst  = 1'b0;
    for (int i = 0; i < 5; i++) randomPixel();
    checkOutput("reset_char_xy", 32'(char_xy), 32'h0);
    checkOutput("reset_rgb", 32'(vout.rgb), 32'h0);
    checkOutput("reset_hcount", 32'(vout.hcount), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) randomPixel();
    idle(4);

    // Cell addressing at the box corners and just outside.
    applyStimulus(280, 104, 1'b0, 1'b0, 12'h111);
    checkOutput("xy_first_cell", 32'(char_xy), 32'h00);
    checkOutput("line_first_cell", 32'(char_line), 32'h0);
    applyStimulus(407, 135, 1'b0, 1'b0, 12'h111);
    checkOutput("xy_last_cell", 32'(char_xy), 32'h1F);
    checkOutput("line_last_cell", 32'(char_line), 32'hF);
    applyStimulus(408, 135, 1'b0, 1'b0, 12'h111);
    checkOutput("xy_right_outside", 32'(char_xy), 32'h00);
    idle(4);

    // Glyph 1000_0001 painted on a line, including the right box edge.
    mode  = 0;
    cap_v = 11'd110;
    for (int h = 276; h <= 292; h++) applyStimulus(h, 110, 1'b0, 1'b0, 12'h123);
    for (int h = 404; h <= 410; h++) applyStimulus(h, 110, 1'b0, 1'b0, 12'h123);
    idle(4);
    checkOutput("paint_279_outside", 32'(cap[279]), 32'h123);
    checkOutput("paint_280", 32'(cap[280]), 32'hFFF);
    checkOutput("paint_281", 32'(cap[281]), 32'h123);
    checkOutput("paint_286", 32'(cap[286]), 32'h123);
    checkOutput("paint_287", 32'(cap[287]), 32'hFFF);
    checkOutput("paint_288", 32'(cap[288]), 32'hFFF);
    checkOutput("paint_407_edge", 32'(cap[407]), 32'hFFF);
    checkOutput("paint_408_outside", 32'(cap[408]), 32'h123);

    // Glyph 0000_1111: cleared pixels either fill or pass through.
    mode  = 2;
    cap_v = 11'd111;
    for (int h = 280; h <= 287; h++) applyStimulus(h, 111, 1'b0, 1'b0, 12'h123);
    idle(4);
`ifdef DRAW_CHAR_OVERLAY_BG_FILL_EN
    checkOutput("fill_280", 32'(cap[280]), 32'h000);
    checkOutput("fill_283", 32'(cap[283]), 32'h000);
`else
    checkOutput("fill_280", 32'(cap[280]), 32'h123);
    checkOutput("fill_283", 32'(cap[283]), 32'h123);
`endif
    checkOutput("fill_284", 32'(cap[284]), 32'hFFF);
    checkOutput("fill_287", 32'(cap[287]), 32'hFFF);

    // Blanking inside the box suppresses painting.
    mode  = 1;
    cap_v = 11'd112;
    for (int h = 280; h <= 287; h++) applyStimulus(h, 112, 1'b1, 1'b0, 12'h456);
    idle(4);
    checkOutput("hblank_282", 32'(cap[282]), 32'h456);
    cap_v = 11'h7FF;

    // Sweep across and around the box with address-dependent glyphs.
    mode = 3;
    for (int v = 102; v <= 137; v++)
      for (int h = 276; h <= 412; h++)
        applyStimulus(h, v, (h == 300 && v == 115), (v == 120), 12'(h * 7 + v));
    idle(4);

    // Mid-frame reset: asynchronous clear, then three zero cycles.
    for (int h = 290; h < 300; h++) applyStimulus(h, 110, 1'b0, 1'b0, 12'h321);
    vin.hcount = 11'd300;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_rgb", 32'(vout.rgb), 32'h0);
    checkOutput("async_reset_hcount", 32'(vout.hcount), 32'h0);
    checkOutput("async_reset_xy", 32'(char_xy), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(301, 110, 1'b0, 1'b0, 12'h321);
    checkOutput("post_reset_1", 32'(vout.hcount), 32'h0);
    applyStimulus(302, 110, 1'b0, 1'b0, 12'h321);
    checkOutput("post_reset_2", 32'(vout.hcount), 32'h0);
    applyStimulus(303, 110, 1'b0, 1'b0, 12'h321);
    checkOutput("post_reset_3", 32'(vout.hcount), 32'd301);
    for (int h = 304; h <= 330; h++) applyStimulus(h, 110, 1'b0, 1'b0, 12'h321);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
